rstn_synchronizer: RTL and testbench
====================================

Name: rstn_synchronizer

Overview:
- Reset conditioner for the TAP/JTAG clock domain.
- Takes a raw active-low reset that is asynchronous to clk and produces a clean active-low reset for downstream logic:
  - synchronizes it through a flop chain;
  - filters short low glitches before accepting an assertion;
  - holds reset asserted for a programmable number of cycles after release.
- Also counts accepted reset events for diagnostics.

Parameters:
SYNC_STAGES, 2, depth of the input synchronizer chain (legal 2..8).
FILTER_CYCLES, 1, consecutive synchronized-low cycles needed to accept an assertion (legal 1..255).
HOLD_CYCLES, 16, consecutive synchronized-high cycles needed before release (legal 1..65535).
CNT_W, 8, width of the reset-event counter.

Ports:
clk  input  1  single clock; all logic is rising-edge.
rst  input  1  synchronous, active-high local reset of this block.
rstn_in  input  1  raw active-low reset, asynchronous to clk.
rstn_out  output  1  conditioned active-low reset, registered.
hold_busy  output  1  high while in HOLD state.
rst_events  output  CNT_W  count of RUN->RESET transitions, saturating.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Local reset (rst=1 at a clk edge):
  - sync chain s[0..SYNC_STAGES-1] all 0;
  - state=RESET, low_cnt=0, hold_cnt=0;
  - rstn_out=0, hold_busy=0, rst_events=0.
  - Mid-operation rst behaves identically and has priority over everything.
- Sync chain:
  - s[0]<=rstn_in; s[i]<=s[i-1].
  - s_sync=s[SYNC_STAGES-1].
  - No logic other than the chain sees rstn_in.
- low_cnt:
  - cleared when s_sync=1;
  - else increments, saturating at FILTER_CYCLES.
  - assert_req = (s_sync==0) && (low_cnt+1 >= FILTER_CYCLES), i.e. the current cycle is included.
- State RESET (rstn_out=0, hold_busy=0):
  - hold_cnt=0;
  - s_sync=1 -> HOLD with hold_cnt=1.
- State HOLD (rstn_out=0, hold_busy=1):
  - s_sync=0 -> RESET immediately; no filtering during HOLD, any low restarts the hold;
  - else hold_cnt==HOLD_CYCLES -> RUN;
  - else hold_cnt++.
- State RUN (rstn_out=1, hold_busy=0):
  - assert_req -> RESET, and rst_events++ (saturate at all-ones);
  - otherwise stay in RUN.
- Registered outputs: rstn_out and hold_busy are registers updated on the same edge as the state, so they reflect the new state right after that edge.
- Release latency: rstn_in rising and stable -> rstn_out=1 after exactly SYNC_STAGES+HOLD_CYCLES+1 clk edges. This is 19 edges at defaults.
- Assertion latency: rstn_in falling and held -> rstn_out=0 after exactly SYNC_STAGES+FILTER_CYCLES edges. This is 3 edges at defaults.
- Glitch filtering:
  - A low pulse on s_sync shorter than FILTER_CYCLES cycles in RUN is ignored: no output change and no count.
  - A low of exactly FILTER_CYCLES cycles is accepted.
- Out-of-range parameter values are a configuration error, and behaviour for them is undefined.
- Only the chain's first flop may go metastable.
- hold_cnt is 16 bits wide and low_cnt is 8 bits wide.

Test Plan:
- rst=1 for 3 cycles with rstn_in=1, then rst=0 -> rstn_out=0, hold_busy rises after 3 edges, rstn_out=1 exactly 19 edges after rst released, rst_events=0.
- In RUN, drive rstn_in=0 for 10 cycles -> rstn_out=0 exactly 3 edges after the falling edge, rst_events=1; after release rstn_out=1 after 19 edges.
- FILTER_CYCLES=4, in RUN, drive 3-cycle low pulse -> rstn_out stays 1, rst_events unchanged; 4-cycle pulse -> rstn_out=0 at edge 6, rst_events increments.
- During HOLD at hold_cnt=10, 1-cycle low on rstn_in -> state returns to RESET, hold restarts, and rstn_out rises only 16 edges after s_sync returns high, plus 1.
- CNT_W=2, cause 5 accepted resets -> rst_events reads 1,2,3,3,3.
- Assert rst while in RUN with rst_events=2 -> next edge rstn_out=0, rst_events=0, chain cleared, then normal release sequence.

Source files
------------

// File: rtl/rstn_synchronizer.sv
// rstn_synchronizer: synchronizes, glitch-filters and stretches an async active-low reset
module rstn_synchronizer #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rstn_in,
  output logic             rstn_out,
  output logic             hold_busy,
  output logic [CNT_W-1:0] rst_events
);
  typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN} state_t;
  state_t state, next;
  logic [SYNC_STAGES-1:0] s;
  logic [7:0] low_cnt;
  logic [15:0] hold_cnt, hold_nxt;
  logic s_sync, assert_req, hold_done, out_nxt, busy_nxt, ev_inc;
  assign s_sync     = s[SYNC_STAGES-1];
  assign assert_req = !s_sync && ({1'b0, low_cnt} + 9'd1 >= 9'(FILTER_CYCLES));
  assign hold_done  = hold_cnt == 16'(HOLD_CYCLES);
  // synchronizer chain; only s[0] ever samples the asynchronous input
  always_ff @(posedge clk)
    if (rst) s <= '0;
    else s <= {s[SYNC_STAGES-2:0], rstn_in};
  // consecutive synchronized-low cycle counter, saturating at the filter length
  always_ff @(posedge clk)
    if (rst || s_sync) low_cnt <= '0;
    else if (low_cnt < 8'(FILTER_CYCLES)) low_cnt <= low_cnt + 8'd1;
  // state register with registered outputs and counters updated alongside it
  always_ff @(posedge clk)
    if (rst) begin
      state      <= ST_RESET;
      hold_cnt   <= '0;
      rstn_out   <= 1'b0;
      hold_busy  <= 1'b0;
      rst_events <= '0;
    end else begin
      state      <= next;
      hold_cnt   <= hold_nxt;
      rstn_out   <= out_nxt;
      hold_busy  <= busy_nxt;
      rst_events <= rst_events + CNT_W'(ev_inc);
    end
  // next state: any low during HOLD restarts it, RUN only leaves on a filtered request
  always_comb
    next = (state == ST_RESET) ? (s_sync ? ST_HOLD : ST_RESET) :
           (state == ST_HOLD)  ? (!s_sync ? ST_RESET : hold_done ? ST_RUN : ST_HOLD) :
                                 (assert_req ? ST_RESET : ST_RUN);
  // next register values derived from the transition
  always_comb begin
    hold_nxt = (next == ST_HOLD) ? ((state == ST_HOLD) ? hold_cnt + 16'd1 : 16'd1) : 16'd0;
    out_nxt  = next == ST_RUN;
    busy_nxt = next == ST_HOLD;
    ev_inc   = (state == ST_RUN) && assert_req && !(&rst_events);
  end
endmodule

// File: tb/tb_rstn_synchronizer.sv
// tb_rstn_synchronizer: directed checks of sync, filter, hold and event counting
module tb_rstn_synchronizer;
  logic clk = 1'b0, rst = 1'b1;
  logic rin_a = 1'b1, rin_f = 1'b1, rin_c = 1'b1;
  logic out_a, out_f, out_c, busy_a, busy_f, busy_c;
  logic [7:0] ev_a, ev_f;
  logic [1:0] ev_c;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rstn_synchronizer dut_a (.clk(clk), .rst(rst), .rstn_in(rin_a), .rstn_out(out_a), .hold_busy(busy_a), .rst_events(ev_a));
  rstn_synchronizer #(.FILTER_CYCLES(4)) dut_f (.clk(clk), .rst(rst), .rstn_in(rin_f), .rstn_out(out_f), .hold_busy(busy_f), .rst_events(ev_f));
  rstn_synchronizer #(.CNT_W(2)) dut_c (.clk(clk), .rst(rst), .rstn_in(rin_c), .rstn_out(out_c), .hold_busy(busy_c), .rst_events(ev_c));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    tests++; if (out_a !== 1'b0) begin fails++; $display("FAIL reset_out got %b want 0", out_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
    tests++; if (ev_a !== 8'd0) begin fails++; $display("FAIL reset_events got %0d want 0", ev_a); end
    rst = 1'b0;
    tick(2);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rel_busy_e2 got %b want 0", busy_a); end
    tick(1);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL rel_busy_e3 got %b want 1", busy_a); end
    tick(15);
    tests++; if (out_a !== 1'b0) begin fails++; $display("FAIL rel_out_e18 got %b want 0", out_a); end
    tick(1);
    tests++; if (out_a !== 1'b1) begin fails++; $display("FAIL rel_out_e19 got %b want 1", out_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rel_busy_e19 got %b want 0", busy_a); end
    tests++; if (ev_a !== 8'd0) begin fails++; $display("FAIL rel_events got %0d want 0", ev_a); end
    tests++; if (out_f !== 1'b1 || out_c !== 1'b1) begin fails++; $display("FAIL rel_others got %b%b want 11", out_f, out_c); end
  endtask

  task automatic test_assert;
    rin_a = 1'b0;
    tick(2);
    tests++; if (out_a !== 1'b1) begin fails++; $display("FAIL assert_e2 got %b want 1", out_a); end
    tick(1);
    tests++; if (out_a !== 1'b0) begin fails++; $display("FAIL assert_e3 got %b want 0", out_a); end
    tests++; if (ev_a !== 8'd1) begin fails++; $display("FAIL assert_events got %0d want 1", ev_a); end
    tick(7);
    rin_a = 1'b1;
    tick(18);
    tests++; if (out_a !== 1'b0) begin fails++; $display("FAIL assert_rel_e18 got %b want 0", out_a); end
    tick(1);
    tests++; if (out_a !== 1'b1) begin fails++; $display("FAIL assert_rel_e19 got %b want 1", out_a); end
  endtask

  task automatic test_filter;
    rin_f = 1'b0;
    tick(3);
    rin_f = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      tests++; if (out_f !== 1'b1) begin fails++; $display("FAIL glitch3_out cyc %0d got %b want 1", i, out_f); end
    end
    tests++; if (ev_f !== 8'd0) begin fails++; $display("FAIL glitch3_events got %0d want 0", ev_f); end
    rin_f = 1'b0;
    tick(4);
    rin_f = 1'b1;
    tick(1);
    tests++; if (out_f !== 1'b1) begin fails++; $display("FAIL pulse4_e5 got %b want 1", out_f); end
    tick(1);
    tests++; if (out_f !== 1'b0) begin fails++; $display("FAIL pulse4_e6 got %b want 0", out_f); end
    tests++; if (ev_f !== 8'd1) begin fails++; $display("FAIL pulse4_events got %0d want 1", ev_f); end
    tick(20);
    tests++; if (out_f !== 1'b1) begin fails++; $display("FAIL pulse4_rel got %b want 1", out_f); end
  endtask

  task automatic test_saturate;
    logic [1:0] exp_ev [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      rin_c = 1'b0;
      tick(3);
      tests++; if (out_c !== 1'b0) begin fails++; $display("FAIL sat_out_low %0d got %b want 0", i, out_c); end
      tests++; if (ev_c !== exp_ev[i]) begin fails++; $display("FAIL sat_events %0d got %0d want %0d", i, ev_c, exp_ev[i]); end
      rin_c = 1'b1;
      tick(19);
      tests++; if (out_c !== 1'b1) begin fails++; $display("FAIL sat_out_rel %0d got %b want 1", i, out_c); end
    end
  endtask

  task automatic test_hold_glitch;
    rin_a = 1'b0;
    tick(4);
    tests++; if (ev_a !== 8'd2) begin fails++; $display("FAIL hg_events got %0d want 2", ev_a); end
    rin_a = 1'b1;
    tick(10);
    rin_a = 1'b0;
    tick(1);
    rin_a = 1'b1;
    tick(1);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL hg_busy_before got %b want 1", busy_a); end
    tick(1);
    tests++; if (busy_a !== 1'b0 || out_a !== 1'b0) begin fails++; $display("FAIL hg_reset got busy %b out %b want 0 0", busy_a, out_a); end
    tick(1);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL hg_rehold got %b want 1", busy_a); end
    tick(15);
    tests++; if (out_a !== 1'b0) begin fails++; $display("FAIL hg_out_early got %b want 0", out_a); end
    tick(1);
    tests++; if (out_a !== 1'b1) begin fails++; $display("FAIL hg_out_rel got %b want 1", out_a); end
    tests++; if (ev_a !== 8'd2) begin fails++; $display("FAIL hg_events_after got %0d want 2", ev_a); end
  endtask

  task automatic test_rst_mid;
    rst = 1'b1;
    tick(1);
    tests++; if (out_a !== 1'b0) begin fails++; $display("FAIL mid_out got %b want 0", out_a); end
    tests++; if (ev_a !== 8'd0) begin fails++; $display("FAIL mid_events got %0d want 0", ev_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy_a); end
    rst = 1'b0;
    tick(2);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_chain_e2 got %b want 0", busy_a); end
    tick(1);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL mid_chain_e3 got %b want 1", busy_a); end
    tick(15);
    tests++; if (out_a !== 1'b0) begin fails++; $display("FAIL mid_rel_e18 got %b want 0", out_a); end
    tick(1);
    tests++; if (out_a !== 1'b1) begin fails++; $display("FAIL mid_rel_e19 got %b want 1", out_a); end
  endtask

  initial begin
    #1;
    test_reset;
    test_assert;
    test_filter;
    test_saturate;
    test_hold_glitch;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
